imem_arbiter: RTL and testbench
===============================

# imem_arbiter

Controller that shares the single-port instruction memory between the fetch stage and a host program loader. After reset it holds the core in BOOT while the host streams program words into memory. On the last word it releases the core. In RUN it steals memory cycles for host writes by stalling fetch, with a bounded burst length so fetch is never starved. It sits between the loader/debug interface, the fetch stage (drives its enable and hold) and the instruction memory port.

## Interface
- DEPTH_WORDS, 256, instruction memory depth in 32-bit words; byte addresses 0 .. DEPTH_WORDS*4-1 are valid
- HOST_BURST, 2, maximum consecutive host grants in RUN before fetch gets one cycle (1..15)

One clock; reset is asynchronous and active-low.

- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous active-low reset
- i_host_valid  in  1  host write request
- i_host_addr  in  32  host byte address
- i_host_data  in  32  host write word
- i_host_last  in  1  marks final boot word (ignored in RUN)
- o_host_ready  out  1  host beat accepted when valid && ready at rising edge
- i_fetch_addr  in  32  current PC from fetch
- o_fetch_en  out  1  fetch PC enable; low = stall
- o_fetch_valid  out  1  memory read data this cycle belongs to fetch; low = inject bubble
- o_core_hold  out  1  holds core pipeline in reset
- o_boot_done  out  1  sticky, boot complete
- o_err  out  1  sticky, bad host address seen
- o_mem_we  out  1  memory write strobe
- o_mem_addr  out  32  memory address (host or fetch)
- o_mem_wdata  out  32  memory write data (= i_host_data)

## Operation
- States: BOOT, RELEASE, RUN. Reset enters BOOT.
- Bad address: i_host_addr[1:0] != 0 or i_host_addr >= DEPTH_WORDS*4. The beat is still accepted (handshake completes). o_mem_we stays 0 and o_err sets; it clears only on reset.
- BOOT:
  - o_core_hold=1, o_fetch_en=0, o_fetch_valid=0, o_host_ready=1.
  - o_mem_addr=i_host_addr.
  - o_mem_we = i_host_valid && good address.
  - An accepted beat with i_host_last=1 moves to RELEASE. This applies even if that beat has a bad address.
- RELEASE (exactly 1 cycle):
  - o_core_hold=0, o_fetch_en=0, o_fetch_valid=0, o_host_ready=0.
  - o_boot_done sets; it is sticky until reset.
  - Next state is RUN.
- RUN:
  - o_core_hold=0.
  - o_host_ready = (burst_cnt < HOST_BURST).
  - Host grant g = i_host_valid && o_host_ready.
  - When g=1: o_mem_addr=i_host_addr, o_mem_we as in BOOT, o_fetch_en=0, o_fetch_valid=0, burst_cnt increments.
  - When g=0: o_mem_addr=i_fetch_addr, o_mem_we=0, o_fetch_en=1, o_fetch_valid=1, burst_cnt clears to 0.
- burst_cnt is a 4-bit counter. Reaching HOST_BURST forces one fetch cycle, which clears it. It never wraps.
- RUN is terminal until reset. i_host_last is ignored in RUN.

## Timing
- Reset values (rst low, asynchronous): state=BOOT, burst_cnt=0, o_boot_done=0, o_err=0, o_core_hold=1, o_host_ready=1.
- While rst is low, o_mem_we, o_fetch_en and o_fetch_valid are forced to 0 regardless of inputs.
- Write latency: the memory write occurs on the same edge as the handshake. o_mem_we is combinational from i_host_valid.
- o_host_ready depends only on registered state; it has no combinational path from i_host_valid.
- o_fetch_en and o_mem_addr in RUN depend combinationally on i_host_valid.
- Last-beat edge sequence:
  - Edge N accepts the last beat.
  - Cycle N+1 is RELEASE: o_core_hold=0, o_boot_done=1.
  - Cycle N+2 is RUN: first fetch of PC 0, o_fetch_en=1.
- Fetch throughput under continuous host traffic is 1 fetch per HOST_BURST+1 cycles.
- Reset asserted mid-boot or mid-RUN returns to BOOT immediately. o_boot_done is lost, and memory contents are not cleared.

## Test plan
- Reset then boot: host writes 0x00000013 to addr 0x0, then 0x00100093 to 0x4 with last=1 -> two o_mem_we pulses; RELEASE one cycle later, o_core_hold falls and o_boot_done=1; next cycle o_fetch_en=1 and o_mem_addr=0x0.
- RUN idle host: PC sequence 0x0, 0x4, 0x8 -> o_mem_addr follows i_fetch_addr, o_fetch_en=1, o_fetch_valid=1 every cycle, o_mem_we=0.
- RUN continuous host valid, HOST_BURST=2 -> repeating grant pattern host, host, fetch. o_host_ready=0 in every third cycle. o_fetch_en/o_fetch_valid=0 on host cycles.
- Bad address: in BOOT, write to 0x2, then to 0x400 (DEPTH_WORDS=256) -> both beats accepted, o_mem_we=0 for both, o_err=1 and stays 1.
- Bad last beat: last=1 with addr 0x401 -> no write, o_err=1, RELEASE still entered the next cycle.
- Reset mid-RUN: drop rst while the host stream is active -> o_core_hold=1, o_fetch_en=0, o_boot_done=0, o_err=0 asynchronously. The bench then re-boots successfully.

Source files
------------

// File: rtl/imem_arbiter_if.sv
// Bundles the host loader, fetch stage and instruction memory signals around imem_arbiter.
// slave is the arbiter side; master is the surrounding core/loader side.
interface imem_arbiter_if;
  logic        i_host_valid;
  logic [31:0] i_host_addr;
  logic [31:0] i_host_data;
  logic        i_host_last;
  logic        o_host_ready;
  logic [31:0] i_fetch_addr;
  logic        o_fetch_en;
  logic        o_fetch_valid;
  logic        o_core_hold;
  logic        o_boot_done;
  logic        o_err;
  logic        o_mem_we;
  logic [31:0] o_mem_addr;
  logic [31:0] o_mem_wdata;

  modport slave (
    input  i_host_valid, i_host_addr, i_host_data, i_host_last, i_fetch_addr,
    output o_host_ready, o_fetch_en, o_fetch_valid, o_core_hold, o_boot_done,
    output o_err, o_mem_we, o_mem_addr, o_mem_wdata
  );

  modport master (
    output i_host_valid, i_host_addr, i_host_data, i_host_last, i_fetch_addr,
    input  o_host_ready, o_fetch_en, o_fetch_valid, o_core_hold, o_boot_done,
    input  o_err, o_mem_we, o_mem_addr, o_mem_wdata
  );
endinterface

// File: rtl/imem_arbiter.sv
// Shares the single-port instruction memory between host loader and fetch: BOOT load, RELEASE, then RUN
// with bounded host bursts. Writes land on the handshake edge; host_ready comes only from registered state.
module imem_arbiter #(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned HOST_BURST  = 2
) (
  input  logic         clk,
  input  logic         rst,
  imem_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    ST_BOOT    = 2'd0,
    ST_RELEASE = 2'd1,
    ST_RUN     = 2'd2
  } state_t;

  localparam logic [31:0] ADDR_LIMIT = 32'(DEPTH_WORDS * 4);
  localparam logic [3:0]  BURST_MAX  = 4'(HOST_BURST);

  state_t      state_q, state_d;
  logic [3:0]  burst_cnt_q, burst_cnt_d;
  logic        boot_done_q, boot_done_d;
  logic        err_q, err_d;

  logic        good_addr;
  logic        accept;
  logic        host_ready;
  logic        fetch_en;
  logic        fetch_valid;
  logic        core_hold;
  logic        mem_we;
  logic [31:0] mem_addr;

  assign good_addr = (bus.i_host_addr[1:0] == 2'b00) && (bus.i_host_addr < ADDR_LIMIT);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_BOOT;
      burst_cnt_q <= 4'd0;
      boot_done_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      burst_cnt_q <= burst_cnt_d;
      boot_done_q <= boot_done_d;
      err_q       <= err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    burst_cnt_d = burst_cnt_q;
    boot_done_d = boot_done_q;
    host_ready  = 1'b0;
    fetch_en    = 1'b0;
    fetch_valid = 1'b0;
    core_hold   = 1'b0;
    mem_we      = 1'b0;
    mem_addr    = bus.i_fetch_addr;
    accept      = 1'b0;

    case (state_q)
      ST_BOOT: begin
        core_hold   = 1'b1;
        host_ready  = 1'b1;
        mem_addr    = bus.i_host_addr;
        accept      = bus.i_host_valid;
        mem_we      = bus.i_host_valid && good_addr;
        burst_cnt_d = 4'd0;
        // A bad-address last beat still ends the boot phase.
        if (bus.i_host_valid && bus.i_host_last) begin
          state_d     = ST_RELEASE;
          boot_done_d = 1'b1;
        end
      end
      ST_RELEASE: begin
        burst_cnt_d = 4'd0;
        state_d     = ST_RUN;
      end
      ST_RUN: begin
        host_ready = (burst_cnt_q < BURST_MAX);
        if (bus.i_host_valid && host_ready) begin
          accept      = 1'b1;
          mem_addr    = bus.i_host_addr;
          mem_we      = good_addr;
          burst_cnt_d = burst_cnt_q + 4'd1;
        end else begin
          // Fetch owns the port; this also forces the cycle that ends a full burst.
          fetch_en    = 1'b1;
          fetch_valid = 1'b1;
          burst_cnt_d = 4'd0;
        end
      end
      default: begin
        state_d     = ST_BOOT;
        burst_cnt_d = 4'd0;
      end
    endcase

    err_d = err_q | (accept & ~good_addr);
  end

  // Strobes are gated by reset so nothing reaches memory or fetch while it is held.
  assign bus.o_host_ready  = host_ready;
  assign bus.o_fetch_en    = fetch_en & rst;
  assign bus.o_fetch_valid = fetch_valid & rst;
  assign bus.o_core_hold   = core_hold;
  assign bus.o_boot_done   = boot_done_q;
  assign bus.o_err         = err_q;
  assign bus.o_mem_we      = mem_we & rst;
  assign bus.o_mem_addr    = mem_addr;
  assign bus.o_mem_wdata   = bus.i_host_data;

endmodule

// File: tb/tb_imem_arbiter.sv
// Table-driven bench for imem_arbiter: per-cycle vectors through a scoreboard queue, plus reset sequences.
module tb_imem_arbiter;

  typedef struct {
    logic        v;
    logic [31:0] a;
    logic [31:0] d;
    logic        last;
    logic [31:0] pc;
    logic        rdy;
    logic        we;
    logic [31:0] maddr;
    logic        fen;
    logic        fval;
    logic        hold;
    logic        done;
    logic        err;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   failures = 0;

  vec_t tbl[$];
  vec_t exp_q[$];

  imem_arbiter_if bus();

  imem_arbiter #(.DEPTH_WORDS(256), .HOST_BURST(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic v, input logic [31:0] a, input logic [31:0] d,
                              input logic last, input logic [31:0] pc, input logic rdy,
                              input logic we, input logic [31:0] maddr, input logic fen,
                              input logic fval, input logic hold, input logic done,
                              input logic err);
    vec_t r;
    r.v = v; r.a = a; r.d = d; r.last = last; r.pc = pc;
    r.rdy = rdy; r.we = we; r.maddr = maddr; r.fen = fen; r.fval = fval;
    r.hold = hold; r.done = done; r.err = err;
    return r;
  endfunction

  task automatic drive_idle();
    bus.i_host_valid = 1'b0;
    bus.i_host_addr  = 32'h0;
    bus.i_host_data  = 32'h0;
    bus.i_host_last  = 1'b0;
    bus.i_fetch_addr = 32'h0;
  endtask

  task automatic run_vectors(input string tag);
    vec_t e;
    for (int i = 0; i < tbl.size(); i++) begin
      @(posedge clk);
      #1;
      bus.i_host_valid = tbl[i].v;
      bus.i_host_addr  = tbl[i].a;
      bus.i_host_data  = tbl[i].d;
      bus.i_host_last  = tbl[i].last;
      bus.i_fetch_addr = tbl[i].pc;
      exp_q.push_back(tbl[i]);
      @(negedge clk);
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL %s[%0d] scoreboard empty", tag, i);
      end else begin
        e = exp_q.pop_front();
        chk($sformatf("%s[%0d].host_ready", tag, i), 32'(bus.o_host_ready), 32'(e.rdy));
        chk($sformatf("%s[%0d].mem_we", tag, i), 32'(bus.o_mem_we), 32'(e.we));
        chk($sformatf("%s[%0d].mem_addr", tag, i), bus.o_mem_addr, e.maddr);
        chk($sformatf("%s[%0d].mem_wdata", tag, i), bus.o_mem_wdata, e.d);
        chk($sformatf("%s[%0d].fetch_en", tag, i), 32'(bus.o_fetch_en), 32'(e.fen));
        chk($sformatf("%s[%0d].fetch_valid", tag, i), 32'(bus.o_fetch_valid), 32'(e.fval));
        chk($sformatf("%s[%0d].core_hold", tag, i), 32'(bus.o_core_hold), 32'(e.hold));
        chk($sformatf("%s[%0d].boot_done", tag, i), 32'(bus.o_boot_done), 32'(e.done));
        chk($sformatf("%s[%0d].err", tag, i), 32'(bus.o_err), 32'(e.err));
      end
    end
    tbl.delete();
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, ".core_hold"}, 32'(bus.o_core_hold), 32'd1);
    chk({tag, ".host_ready"}, 32'(bus.o_host_ready), 32'd1);
    chk({tag, ".mem_we"}, 32'(bus.o_mem_we), 32'd0);
    chk({tag, ".fetch_en"}, 32'(bus.o_fetch_en), 32'd0);
    chk({tag, ".fetch_valid"}, 32'(bus.o_fetch_valid), 32'd0);
    chk({tag, ".boot_done"}, 32'(bus.o_boot_done), 32'd0);
    chk({tag, ".err"}, 32'(bus.o_err), 32'd0);
  endtask

  initial begin
    // Held in reset with a valid, well-formed beat present: no write may escape.
    drive_idle();
    bus.i_host_valid = 1'b1;
    bus.i_host_data  = 32'hdead_beef;
    repeat (2) @(negedge clk);
    chk_reset_outputs("reset");
    bus.i_host_valid = 1'b0;
    @(posedge clk);
    #1 rst = 1'b1;

    //            v   addr          data          last pc            rdy we maddr         fen fv hold done err
    tbl.push_back(mk(1, 32'h0,        32'h00000013, 0, 32'h0,        1,  1, 32'h0,        0,  0, 1,   0,   0));
    tbl.push_back(mk(1, 32'h4,        32'h00100093, 1, 32'h0,        1,  1, 32'h4,        0,  0, 1,   0,   0));
    tbl.push_back(mk(0, 32'h0,        32'h0,        0, 32'h0,        0,  0, 32'h0,        0,  0, 0,   1,   0));
    tbl.push_back(mk(0, 32'h0,        32'h0,        0, 32'h0,        1,  0, 32'h0,        1,  1, 0,   1,   0));
    tbl.push_back(mk(0, 32'h0,        32'h0,        0, 32'h4,        1,  0, 32'h4,        1,  1, 0,   1,   0));
    tbl.push_back(mk(0, 32'h0,        32'h0,        0, 32'h8,        1,  0, 32'h8,        1,  1, 0,   1,   0));
    tbl.push_back(mk(1, 32'h10,       32'h11111111, 0, 32'hC,        1,  1, 32'h10,       0,  0, 0,   1,   0));
    tbl.push_back(mk(1, 32'h14,       32'h22222222, 0, 32'hC,        1,  1, 32'h14,       0,  0, 0,   1,   0));
    tbl.push_back(mk(1, 32'h18,       32'h33333333, 0, 32'hC,        0,  0, 32'hC,        1,  1, 0,   1,   0));
    tbl.push_back(mk(1, 32'h18,       32'h33333333, 1, 32'h10,       1,  1, 32'h18,       0,  0, 0,   1,   0));
    tbl.push_back(mk(1, 32'h1C,       32'h44444444, 0, 32'h10,       1,  1, 32'h1C,       0,  0, 0,   1,   0));
    tbl.push_back(mk(1, 32'h20,       32'h55555555, 0, 32'h10,       0,  0, 32'h10,       1,  1, 0,   1,   0));
    tbl.push_back(mk(1, 32'h401,      32'h66666666, 0, 32'h14,       1,  0, 32'h401,      0,  0, 0,   1,   0));
    tbl.push_back(mk(0, 32'h0,        32'h0,        0, 32'h14,       1,  0, 32'h14,       1,  1, 0,   1,   1));
    run_vectors("boot_run");

    // Reset dropped mid-cycle with the host stream active; outputs must respond without a clock edge.
    @(posedge clk);
    #1;
    bus.i_host_valid = 1'b1;
    bus.i_host_addr  = 32'h24;
    bus.i_host_data  = 32'h77777777;
    #2 rst = 1'b0;
    #1 chk_reset_outputs("async_rst");
    repeat (2) @(negedge clk);
    chk_reset_outputs("held_rst");
    drive_idle();
    @(posedge clk);
    #1 rst = 1'b1;

    //            v   addr          data          last pc            rdy we maddr         fen fv hold done err
    tbl.push_back(mk(1, 32'h2,        32'hAAAA0001, 0, 32'h0,        1,  0, 32'h2,        0,  0, 1,   0,   0));
    tbl.push_back(mk(1, 32'h400,      32'hAAAA0002, 0, 32'h0,        1,  0, 32'h400,      0,  0, 1,   0,   1));
    tbl.push_back(mk(1, 32'h3FC,      32'hAAAA0003, 0, 32'h0,        1,  1, 32'h3FC,      0,  0, 1,   0,   1));
    tbl.push_back(mk(1, 32'h401,      32'hAAAA0004, 1, 32'h0,        1,  0, 32'h401,      0,  0, 1,   0,   1));
    tbl.push_back(mk(0, 32'h0,        32'h0,        0, 32'h0,        0,  0, 32'h0,        0,  0, 0,   1,   1));
    tbl.push_back(mk(0, 32'h0,        32'h0,        0, 32'h0,        1,  0, 32'h0,        1,  1, 0,   1,   1));
    tbl.push_back(mk(1, 32'h8,        32'hBBBB0001, 0, 32'h4,        1,  1, 32'h8,        0,  0, 0,   1,   1));
    tbl.push_back(mk(0, 32'h0,        32'h0,        0, 32'h4,        1,  0, 32'h4,        1,  1, 0,   1,   1));
    run_vectors("reboot");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
